bp_fetch_unit: RTL and testbench

Parametrised fetch stage for the 5-stage RISC-V pipeline: owns the PC register and adds dynamic branch prediction through a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. The core's execute stage reports resolved branches and jumps. On a misprediction this block redirects the PC and raises a flush to the IF/ID and ID/EX registers. Replaces the fixed PC+4 / taken-in-EX fetch logic.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/branch_target_buffer.sv | 112 +++++++++++
 rtl/bp_fetch_unit.sv | 110 +++++++++++
 tb/tb_bp_fetch_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared constants for the 5-stage RISC-V pipeline: default
//             widths, reset vector and 2-bit branch predictor encodings.
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int          c_XLEN_DEFAULT     = 32;
    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;

    // 2-bit saturating counter encodings; the MSB is the taken prediction
    localparam logic [1:0] c_CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] c_CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] c_CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] c_CTR_STRONG_T  = 2'b11;

    // Saturating step of a 2-bit predictor counter toward the actual outcome
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == c_CTR_STRONG_T) ? ctr : ctr + 2'd1;
        end
        return (ctr == c_CTR_STRONG_NT) ? ctr : ctr - 2'd1;
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : branch_target_buffer
//  Purpose  : Direct-mapped BTB with 2-bit saturating counters. One
//             combinational lookup port (fetch) and one registered update
//             port (execute). Lookup sees pre-update contents (no bypass).
//  Revision : 1.0 - initial release
// ============================================================================
import riscv_pkg::*;

module branch_target_buffer #(
    parameter int XLEN    = c_XLEN_DEFAULT,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    // lookup port
    input  logic [XLEN-1:0] i_lookup_pc,
    output logic            o_lookup_hit,
    output logic            o_lookup_taken,
    output logic [XLEN-1:0] o_lookup_target,
    // update port
    input  logic            i_upd_valid,
    input  logic            i_upd_branch,
    input  logic            i_upd_jump,
    input  logic            i_upd_taken,
    input  logic [XLEN-1:0] i_upd_pc,
    input  logic [XLEN-1:0] i_upd_target
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [XLEN-1:0]    r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    logic [IDX-1:0]   w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX-1:0]   w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_resolve;
    logic             w_alloc;
    logic             w_invalidate;
    logic             w_wr_ctr;
    logic             w_wr_target;
    logic [1:0]       w_ctr_next;
    logic             w_unused_bits;

    // Word-aligned PCs: the two LSBs never take part in index or tag
    assign w_unused_bits = &{1'b0, i_lookup_pc[1:0], i_upd_pc[1:0]};

    assign w_lk_idx = i_lookup_pc[IDX+1:2];
    assign w_lk_tag = i_lookup_pc[XLEN-1:IDX+2];
    assign w_up_idx = i_upd_pc[IDX+1:2];
    assign w_up_tag = i_upd_pc[XLEN-1:IDX+2];

    // Fetch-side lookup: predict taken only on a tag hit with counter MSB set
    always_comb begin
        o_lookup_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
        o_lookup_taken  = o_lookup_hit && r_ctr[w_lk_idx][1];
        o_lookup_target = r_target[w_lk_idx];
    end

    // Update decision for the instruction currently resolving in EX
    always_comb begin
        w_up_hit     = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
        w_resolve    = i_upd_valid && (i_upd_branch || i_upd_jump);
        w_alloc      = w_resolve && !w_up_hit && i_upd_taken;
        // A hit on something that is not a branch/jump means the entry is stale or aliased
        w_invalidate = i_upd_valid && !w_resolve && w_up_hit;
        w_wr_ctr     = w_resolve && (w_up_hit || i_upd_taken);
        w_wr_target  = w_resolve && i_upd_taken;
        if (i_upd_jump) begin
            w_ctr_next = c_CTR_STRONG_T;
        end else if (w_up_hit) begin
            w_ctr_next = ctr_update(r_ctr[w_up_idx], i_upd_taken);
        end else begin
            w_ctr_next = c_CTR_WEAK_T;
        end
    end

    // Valid bits are the only BTB state that needs reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_alloc) begin
            r_valid[w_up_idx] <= 1'b1;
        end else if (w_invalidate) begin
            r_valid[w_up_idx] <= 1'b0;
        end
    end

    // Payload storage; writes are suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_alloc) begin
                r_tag[w_up_idx] <= w_up_tag;
            end
            if (w_wr_target) begin
                r_target[w_up_idx] <= i_upd_target;
            end
            if (w_wr_ctr) begin
                r_ctr[w_up_idx] <= w_ctr_next;
            end
        end
    end

endmodule : branch_target_buffer
`default_nettype wire

// File: rtl/bp_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : bp_fetch_unit
//  Purpose  : Fetch stage with BTB-based dynamic branch prediction. Owns the
//             PC, detects mispredictions for the EX-stage instruction,
//             redirects the PC and keeps branch/mispredict statistics.
//  Revision : 1.0 - initial release
// ============================================================================
import riscv_pkg::*;

module bp_fetch_unit #(
    parameter int              XLEN        = c_XLEN_DEFAULT,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(c_RESET_PC_DEFAULT),
    parameter int              CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCWrite,
    output logic [XLEN-1:0]  PC_F,
    output logic [XLEN-1:0]  PCPlus4_F,
    output logic             PredTaken_F,
    output logic [XLEN-1:0]  PredTarget_F,
    input  logic             Valid_E,
    input  logic             Branch_E,
    input  logic             Jump_E,
    input  logic             Taken_E,
    input  logic [XLEN-1:0]  PC_E,
    input  logic [XLEN-1:0]  Target_E,
    input  logic             PredTaken_E,
    input  logic [XLEN-1:0]  PredTarget_E,
    output logic             Mispredict_E,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MispredictCount
);

    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispredict_cnt;

    logic             w_btb_hit;
    logic             w_btb_taken;
    logic [XLEN-1:0]  w_btb_target;
    logic             w_resolve;
    logic [XLEN-1:0]  w_correct_pc;
    logic             w_mispredict;

    branch_target_buffer #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk             (clk),
        .rst             (reset),
        .i_lookup_pc     (r_pc),
        .o_lookup_hit    (w_btb_hit),
        .o_lookup_taken  (w_btb_taken),
        .o_lookup_target (w_btb_target),
        .i_upd_valid     (Valid_E),
        .i_upd_branch    (Branch_E),
        .i_upd_jump      (Jump_E),
        .i_upd_taken     (Taken_E),
        .i_upd_pc        (PC_E),
        .i_upd_target    (Target_E)
    );

    // Fetch-side outputs; prediction is available in the same cycle as the PC
    always_comb begin
        PC_F         = r_pc;
        PCPlus4_F    = r_pc + XLEN'(4);
        PredTaken_F  = w_btb_taken;
        PredTarget_F = w_btb_taken ? w_btb_target : PCPlus4_F;
    end

    // Misprediction check: a taken prediction must match the real next PC
    // exactly; this also catches stale entries firing on non-branches
    always_comb begin
        w_resolve    = Valid_E && (Branch_E || Jump_E);
        w_correct_pc = Taken_E ? Target_E : (PC_E + XLEN'(4));
        w_mispredict = Valid_E && (PredTaken_E ? (PredTarget_E != w_correct_pc)
                                               : (w_resolve && Taken_E));
        Mispredict_E = w_mispredict;
    end

    // PC register: redirect beats the hazard-unit stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (w_mispredict) begin
            r_pc <= w_correct_pc;
        end else if (PCWrite) begin
            r_pc <= PredTarget_F;
        end
    end

    // Performance counters, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            r_branch_cnt     <= r_branch_cnt + CNT_W'(w_resolve);
            r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(w_mispredict);
        end
    end

    assign BranchCount     = r_branch_cnt;
    assign MispredictCount = r_mispredict_cnt;

endmodule : bp_fetch_unit
`default_nettype wire

// File: tb/tb_bp_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_fetch_unit
//  Purpose  : Directed self-checking bench for bp_fetch_unit (4-entry BTB,
//             reset vector 0x100). Expected values are queued when stimulus
//             is applied and popped when the DUT output is sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bp_fetch_unit;

    logic        clk;
    logic        reset;
    logic        PCWrite;
    logic [31:0] PC_F;
    logic [31:0] PCPlus4_F;
    logic        PredTaken_F;
    logic [31:0] PredTarget_F;
    logic        Valid_E;
    logic        Branch_E;
    logic        Jump_E;
    logic        Taken_E;
    logic [31:0] PC_E;
    logic [31:0] Target_E;
    logic        PredTaken_E;
    logic [31:0] PredTarget_E;
    logic        Mispredict_E;
    logic [31:0] BranchCount;
    logic [31:0] MispredictCount;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_bc   = 0;
    logic [31:0] exp_mc   = 0;

    bp_fetch_unit #(
        .XLEN        (32),
        .BTB_ENTRIES (4),
        .RESET_PC    (32'h100),
        .CNT_W       (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .PCWrite         (PCWrite),
        .PC_F            (PC_F),
        .PCPlus4_F       (PCPlus4_F),
        .PredTaken_F     (PredTaken_F),
        .PredTarget_F    (PredTarget_F),
        .Valid_E         (Valid_E),
        .Branch_E        (Branch_E),
        .Jump_E          (Jump_E),
        .Taken_E         (Taken_E),
        .PC_E            (PC_E),
        .Target_E        (Target_E),
        .PredTaken_E     (PredTaken_E),
        .PredTarget_E    (PredTarget_E),
        .Mispredict_E    (Mispredict_E),
        .BranchCount     (BranchCount),
        .MispredictCount (MispredictCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic idle_ex();
        Valid_E      = 1'b0;
        Branch_E     = 1'b0;
        Jump_E       = 1'b0;
        Taken_E      = 1'b0;
        PC_E         = '0;
        Target_E     = '0;
        PredTaken_E  = 1'b0;
        PredTarget_E = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts();
        push("branch_count", exp_bc);
        check(BranchCount);
        push("mispredict_count", exp_mc);
        check(MispredictCount);
    endtask

    // One valid EX-stage instruction for a cycle, then the resulting PC
    task automatic ex(input logic br, input logic jmp, input logic tk,
                      input logic [31:0] pce, input logic [31:0] tgt,
                      input logic pt, input logic [31:0] ptg,
                      input logic exp_m, input logic [31:0] exp_pc);
        Valid_E      = 1'b1;
        Branch_E     = br;
        Jump_E       = jmp;
        Taken_E      = tk;
        PC_E         = pce;
        Target_E     = tgt;
        PredTaken_E  = pt;
        PredTarget_E = ptg;
        push("mispredict_e", {31'd0, exp_m});
        #1;
        check({31'd0, Mispredict_E});
        if (br || jmp) exp_bc++;
        if (exp_m)     exp_mc++;
        tick();
        idle_ex();
        push("pc_f", exp_pc);
        check(PC_F);
        check_counts();
    endtask

    // Steer fetch to pc via a non-branch whose bogus taken prediction is corrected
    task automatic redirect(input logic [31:0] pc);
        ex(1'b0, 1'b0, 1'b0, pc - 32'd4, 32'd0, 1'b1, pc + 32'h100, 1'b1, pc);
    endtask

    task automatic chk_pred(input logic tk, input logic [31:0] tgt);
        push("pred_taken_f", {31'd0, tk});
        check({31'd0, PredTaken_F});
        push("pred_target_f", tgt);
        check(PredTarget_F);
    endtask

    initial begin
        reset   = 1'b1;
        PCWrite = 1'b1;
        idle_ex();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state and sequential fetch
        push("reset_pc_f", 32'h100);      check(PC_F);
        push("reset_pcplus4", 32'h104);   check(PCPlus4_F);
        chk_pred(1'b0, 32'h104);
        check_counts();
        tick(); push("seq_pc_f", 32'h104); check(PC_F);
        tick(); push("seq_pc_f", 32'h108); check(PC_F);

        // first encounter of taken branch 0x10 -> 0x40
        ex(1'b1, 1'b0, 1'b1, 32'h10, 32'h40, 1'b0, 32'h14, 1'b1, 32'h40);
        redirect(32'h10);
        chk_pred(1'b1, 32'h40);

        // loop: taken three times with correct prediction, then exit
        ex(1'b1, 1'b0, 1'b1, 32'h10, 32'h40, 1'b1, 32'h40, 1'b0, 32'h40);
        ex(1'b1, 1'b0, 1'b1, 32'h10, 32'h40, 1'b1, 32'h40, 1'b0, 32'h44);
        ex(1'b1, 1'b0, 1'b1, 32'h10, 32'h40, 1'b1, 32'h40, 1'b0, 32'h48);
        ex(1'b1, 1'b0, 1'b0, 32'h10, 32'h40, 1'b1, 32'h40, 1'b1, 32'h14);
        redirect(32'h10);
        chk_pred(1'b1, 32'h40);           // strong-taken stepped down to weak-taken

        // walk counter down to strong-not-taken and check floor saturation
        ex(1'b1, 1'b0, 1'b0, 32'h10, 32'h40, 1'b1, 32'h40, 1'b1, 32'h14);
        redirect(32'h10);
        chk_pred(1'b0, 32'h14);           // weak-not-taken
        ex(1'b1, 1'b0, 1'b0, 32'h10, 32'h40, 1'b0, 32'h14, 1'b0, 32'h14);
        ex(1'b1, 1'b0, 1'b0, 32'h10, 32'h40, 1'b0, 32'h14, 1'b0, 32'h18);
        ex(1'b1, 1'b0, 1'b1, 32'h10, 32'h40, 1'b0, 32'h14, 1'b1, 32'h40);
        redirect(32'h10);
        chk_pred(1'b0, 32'h14);           // 00 held, then +1 gives weak-not-taken

        // jump on a hit sets strong-taken and rewrites target
        ex(1'b0, 1'b1, 1'b1, 32'h10, 32'h50, 1'b0, 32'h14, 1'b1, 32'h50);
        redirect(32'h10);
        chk_pred(1'b1, 32'h50);

        // aliasing: 0x00 shares index 0 but has a different tag
        redirect(32'h00);
        chk_pred(1'b0, 32'h04);

        // stale entry fires on a non-branch: redirect to fall-through and invalidate
        ex(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 32'h50, 1'b1, 32'h14);
        redirect(32'h10);
        chk_pred(1'b0, 32'h14);

        // redirect overrides a stall; a stall alone holds the PC
        PCWrite = 1'b0;
        ex(1'b1, 1'b0, 1'b1, 32'h20, 32'h60, 1'b0, 32'h24, 1'b1, 32'h60);
        tick(); push("stall_pc_f", 32'h60); check(PC_F);
        tick(); push("stall_pc_f", 32'h60); check(PC_F);
        PCWrite = 1'b1;

        // allocate an entry, then reset in the same cycle as another allocation
        ex(1'b1, 1'b0, 1'b1, 32'h34, 32'h80, 1'b0, 32'h38, 1'b1, 32'h80);
        reset        = 1'b1;
        Valid_E      = 1'b1;
        Branch_E     = 1'b1;
        Taken_E      = 1'b1;
        PC_E         = 32'h38;
        Target_E     = 32'h90;
        PredTaken_E  = 1'b0;
        PredTarget_E = 32'h3C;
        #1;
        push("mispredict_in_reset", 32'd1);
        check({31'd0, Mispredict_E});
        tick();
        reset = 1'b0;
        idle_ex();
        exp_bc = 0;
        exp_mc = 0;
        push("post_reset_pc_f", 32'h100);
        check(PC_F);
        check_counts();
        redirect(32'h34);
        chk_pred(1'b0, 32'h38);           // valid bit cleared by reset
        redirect(32'h38);
        chk_pred(1'b0, 32'h3C);           // allocation during reset was dropped

        if (sb.size() != 0) begin
            n_checks++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_bp_fetch_unit
`default_nettype wire
